// File: rtl/ctrl_issue_pkg.sv
// Shared types for the issue stage: execution-unit selector, the decoded uop
// word that DEC hands to issue, and the scoreboard mask helper.
package exut;
  typedef enum logic [1:0] {
    EXU_ALU = 2'd0,
    EXU_MUL = 2'd1,
    EXU_LSU = 2'd2,
    EXU_BRU = 2'd3
  } exe_unit_type_t;
endpackage

package issq;
  localparam int NUM_REGS = 32;
  localparam int REG_W    = 5;
  localparam int NUM_EXU  = 4;

  typedef struct packed {
    logic [6:0]           uopcode;
    exut::exe_unit_type_t exu_type;
    logic [1:0]           iq_type;
    logic                 has_rd;
    logic                 has_rs1;
    logic                 has_rs2;
    logic [REG_W-1:0]     rd;
    logic [REG_W-1:0]     rs1;
    logic [REG_W-1:0]     rs2;
    logic [2:0]           imm_type;
    logic                 is_br;
    logic                 is_jal;
    logic                 is_jalr;
    logic [19:0]          packed_imm;
    logic [31:0]          instr;
  } issue_uop_t;

  // One-hot register mask; x0 is excluded so it can never become busy.
  function automatic logic [NUM_REGS-1:0] busy_mask(input logic valid,
                                                    input logic [REG_W-1:0] rd);
    logic [NUM_REGS-1:0] m;
    m = '0;
    if (valid && (rd != '0)) m[rd] = 1'b1;
    return m;
  endfunction
endpackage

// File: rtl/ctrl_issue_scoreboard.sv
// 32-entry register scoreboard: writebacks clear, issue sets; a set wins over
// a same-cycle clear of the same register.
module reg_scoreboard
  import issq::*;
#(
  parameter int WB_PORTS = 2
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            set_valid,
  input  logic [REG_W-1:0]                set_rd,
  input  logic [WB_PORTS-1:0]             wb_valid,
  input  logic [WB_PORTS-1:0][REG_W-1:0]  wb_rd,
  output logic [NUM_REGS-1:0]             busy,
  output logic [NUM_REGS-1:0]             busy_eff
);

  logic [NUM_REGS-1:0] wb_clear;
  logic [NUM_REGS-1:0] busy_nxt;

  always_comb begin
    wb_clear = '0;
    for (int p = 0; p < WB_PORTS; p++) begin
      wb_clear = wb_clear | busy_mask(wb_valid[p], wb_rd[p]);
    end
  end

  // busy_eff is the view seen by the hazard check this cycle, so a writeback
  // unblocks the head with zero latency.
  assign busy_eff = busy & ~wb_clear;
  assign busy_nxt = busy_eff | busy_mask(set_valid, set_rd);

  always_ff @(posedge clk) begin
    if (rst) begin
      busy <= '0;
    end else begin
      busy <= busy_nxt;
    end
  end

endmodule

// File: rtl/ctrl_issue.sv
// In-order issue stage: circular uop buffer, head-of-queue hazard check against
// the register scoreboard, and hand-off to the execution unit named by exu_type.
module ctrl_issue
  import issq::*;
#(
  parameter int DEPTH    = 4,
  parameter int WB_PORTS = 2
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            flush,
  input  logic                            enq_valid,
  output logic                            enq_ready,
  input  issue_uop_t                      enq_uop,
  output logic                            iss_valid,
  output issue_uop_t                      iss_uop,
  input  logic [NUM_EXU-1:0]              exu_ready,
  output logic                            iss_fire,
  input  logic [WB_PORTS-1:0]             wb_valid,
  input  logic [WB_PORTS-1:0][REG_W-1:0]  wb_rd,
  output logic [NUM_REGS-1:0]             busy
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PTR_W:0] CNT_FULL = (PTR_W + 1)'(DEPTH);

  issue_uop_t          mem [DEPTH];
  logic [PTR_W-1:0]    head;
  logic [PTR_W-1:0]    tail;
  logic [PTR_W:0]      count;
  logic                do_enq;
  logic [NUM_REGS-1:0] busy_eff;
  logic                blk_rs1;
  logic                blk_rs2;
  logic                blk_rd;
  logic                set_valid;

  assign enq_ready = (count != CNT_FULL);
  assign do_enq    = enq_valid & enq_ready & ~flush;
  assign iss_uop   = mem[head];

  // RAW on either source, WAW on the destination.
  assign blk_rs1 = iss_uop.has_rs1 & busy_eff[iss_uop.rs1];
  assign blk_rs2 = iss_uop.has_rs2 & busy_eff[iss_uop.rs2];
  assign blk_rd  = iss_uop.has_rd  & busy_eff[iss_uop.rd];

  assign iss_valid = (count != '0) & ~flush & ~blk_rs1 & ~blk_rs2 & ~blk_rd;
  assign iss_fire  = iss_valid & exu_ready[iss_uop.exu_type];
  assign set_valid = iss_fire & iss_uop.has_rd;

  // Payload storage carries no reset; occupancy is tracked by count alone.
  always_ff @(posedge clk) begin
    if (do_enq) mem[tail] <= enq_uop;
  end

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (do_enq)   tail <= tail + 1'b1;
      if (iss_fire) head <= head + 1'b1;
      case ({do_enq, iss_fire})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // The scoreboard survives flush: squashed-path uops already issued still write back.
  reg_scoreboard #(
    .WB_PORTS (WB_PORTS)
  ) u_sb (
    .clk       (clk),
    .rst       (rst),
    .set_valid (set_valid),
    .set_rd    (iss_uop.rd),
    .wb_valid  (wb_valid),
    .wb_rd     (wb_rd),
    .busy      (busy),
    .busy_eff  (busy_eff)
  );

endmodule

// File: tb/tb_ctrl_issue.sv
// Directed bench for ctrl_issue: streaming, RAW/WAW stalls, full/wrap,
// writeback/issue collision, flush, x0 handling and mid-run reset.
module tb_ctrl_issue;
  import issq::*;
  import exut::*;

  logic                  clk;
  logic                  rst;
  logic                  flush;
  logic                  enq_valid;
  logic                  enq_ready;
  issue_uop_t            enq_uop;
  logic                  iss_valid;
  issue_uop_t            iss_uop;
  logic [3:0]            exu_ready;
  logic                  iss_fire;
  logic [1:0]            wb_valid;
  logic [1:0][4:0]       wb_rd;
  logic [31:0]           busy;

  int n_chk  = 0;
  int n_fail = 0;

  ctrl_issue #(.DEPTH(4), .WB_PORTS(2)) dut (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .enq_valid (enq_valid),
    .enq_ready (enq_ready),
    .enq_uop   (enq_uop),
    .iss_valid (iss_valid),
    .iss_uop   (iss_uop),
    .exu_ready (exu_ready),
    .iss_fire  (iss_fire),
    .wb_valid  (wb_valid),
    .wb_rd     (wb_rd),
    .busy      (busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic issue_uop_t mk(input logic [31:0] id, input exe_unit_type_t exu,
                                    input logic hrd, input logic [4:0] rd,
                                    input logic hrs1, input logic [4:0] rs1,
                                    input logic hrs2, input logic [4:0] rs2);
    issue_uop_t u;
    u = '0;
    u.uopcode  = 7'h13;
    u.exu_type = exu;
    u.has_rd   = hrd;
    u.rd       = rd;
    u.has_rs1  = hrs1;
    u.rs1      = rs1;
    u.has_rs2  = hrs2;
    u.rs2      = rs2;
    u.instr    = id;
    return u;
  endfunction

  initial begin
    rst = 1'b1; flush = 1'b0; enq_valid = 1'b0; enq_uop = '0;
    exu_ready = 4'b0000; wb_valid = 2'b00; wb_rd = '0;
    tick(); tick();
    #2;
    chk("rst_enq_ready", enq_ready, 1);
    chk("rst_iss_valid", iss_valid, 0);
    chk("rst_iss_fire", iss_fire, 0);
    chk("rst_busy", busy, 0);
    rst = 1'b0;
    tick();

    // Stream of 4 independent addi x1..x4
    exu_ready = 4'b1111;
    for (int i = 0; i <= 4; i++) begin
      if (i < 4) begin
        enq_valid = 1'b1;
        enq_uop = mk(i + 1, EXU_ALU, 1'b1, 5'(i + 1), 1'b1, 5'd0, 1'b0, 5'd0);
      end else begin
        enq_valid = 1'b0;
      end
      #2;
      chk("strm_enq_ready", enq_ready, 1);
      if (i == 0) begin
        chk("strm_empty_valid", iss_valid, 0);
      end else begin
        chk("strm_fire", iss_fire, 1);
        chk("strm_order", iss_uop.instr, i);
      end
      tick();
    end
    #2;
    chk("strm_busy", busy, 32'h0000_001E);
    chk("strm_drained", iss_valid, 0);

    // Clear x2..x4 (duplicate wb_rd on second cycle)
    wb_valid = 2'b11; wb_rd[0] = 5'd2; wb_rd[1] = 5'd3;
    tick();
    wb_rd[0] = 5'd4; wb_rd[1] = 5'd4;
    tick();
    wb_valid = 2'b00;
    #2;
    chk("wb_dup_busy", busy, 32'h0000_0002);

    // RAW stall: add x5,x1,x2 with x1 busy
    enq_valid = 1'b1;
    enq_uop = mk(32'h50, EXU_ALU, 1'b1, 5'd5, 1'b1, 5'd1, 1'b1, 5'd2);
    tick();
    enq_valid = 1'b0;
    #2;
    chk("raw_blocked0", iss_valid, 0);
    tick();
    #2;
    chk("raw_blocked1", iss_valid, 0);
    wb_valid = 2'b01; wb_rd[0] = 5'd1;
    #2;
    chk("raw_wb_valid", iss_valid, 1);
    chk("raw_wb_fire", iss_fire, 1);
    tick();
    wb_valid = 2'b00;
    #2;
    chk("raw_busy", busy, 32'h0000_0020);
    chk("raw_empty", iss_valid, 0);

    // Full/wrap with exu_ready = 0 (head starts at index 1)
    exu_ready = 4'b0000;
    for (int i = 0; i < 4; i++) begin
      enq_valid = 1'b1;
      enq_uop = mk(32'h10 + i, EXU_ALU, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0);
      #2;
      chk("full_enq_ready", enq_ready, 1);
      tick();
    end
    enq_uop = mk(32'h14, EXU_ALU, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0);
    #2;
    chk("full_enq_ready0", enq_ready, 0);
    chk("full_head_valid", iss_valid, 1);
    chk("full_no_fire", iss_fire, 0);
    tick();
    #2;
    chk("full_held_count", dut.count, 4);
    exu_ready = 4'b1111;
    #2;
    chk("drain0_fire", iss_fire, 1);
    chk("drain0_id", iss_uop.instr, 32'h10);
    chk("drain0_enq_ready", enq_ready, 0);
    tick();
    #2;
    chk("drain1_enq_ready", enq_ready, 1);
    chk("drain1_id", iss_uop.instr, 32'h11);
    tick();
    enq_valid = 1'b0;
    for (int i = 2; i < 5; i++) begin
      #2;
      chk("drain_fire", iss_fire, 1);
      chk("drain_id", iss_uop.instr, 32'h10 + i);
      tick();
    end
    #2;
    chk("drain_empty", iss_valid, 0);

    // WB/issue collision on x7
    enq_valid = 1'b1;
    enq_uop = mk(32'h70, EXU_ALU, 1'b1, 5'd7, 1'b1, 5'd0, 1'b0, 5'd0);
    tick();
    enq_valid = 1'b0;
    #2;
    chk("x7_fire", iss_fire, 1);
    tick();
    #2;
    chk("x7_busy", busy, 32'h0000_00A0);
    exu_ready = 4'b0010;
    enq_valid = 1'b1;
    enq_uop = mk(32'h71, EXU_MUL, 1'b1, 5'd7, 1'b1, 5'd8, 1'b1, 5'd9);
    tick();
    enq_valid = 1'b0;
    #2;
    chk("waw_blocked", iss_valid, 0);
    wb_valid = 2'b10; wb_rd[1] = 5'd7;
    #2;
    chk("coll_fire", iss_fire, 1);
    chk("coll_id", iss_uop.instr, 32'h71);
    tick();
    wb_valid = 2'b00;
    #2;
    chk("coll_set_wins", busy, 32'h0000_00A0);

    // Flush with 3 buffered uops and a simultaneous enqueue
    exu_ready = 4'b0000;
    for (int i = 0; i < 3; i++) begin
      enq_valid = 1'b1;
      enq_uop = mk(32'h20 + i, EXU_ALU, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0);
      tick();
    end
    enq_uop = mk(32'h23, EXU_ALU, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0);
    flush = 1'b1;
    exu_ready = 4'b1111;
    #2;
    chk("flush_valid", iss_valid, 0);
    chk("flush_fire", iss_fire, 0);
    tick();
    flush = 1'b0; enq_valid = 1'b0;
    #2;
    chk("flush_count", dut.count, 0);
    chk("flush_head", dut.head, 0);
    chk("flush_tail", dut.tail, 0);
    chk("flush_dropped", iss_valid, 0);
    chk("flush_enq_ready", enq_ready, 1);
    chk("flush_busy", busy, 32'h0000_00A0);
    wb_valid = 2'b11; wb_rd[0] = 5'd5; wb_rd[1] = 5'd7;
    tick();
    wb_valid = 2'b00;
    #2;
    chk("flush_wb_clear", busy, 0);

    // x0 destination never sets busy[0]
    enq_valid = 1'b1;
    enq_uop = mk(32'h30, EXU_ALU, 1'b1, 5'd0, 1'b1, 5'd0, 1'b0, 5'd0);
    tick();
    enq_valid = 1'b0;
    #2;
    chk("x0_fire", iss_fire, 1);
    tick();
    #2;
    chk("x0_busy", busy, 0);

    // Reset with a full buffer and a busy register
    enq_valid = 1'b1;
    enq_uop = mk(32'h40, EXU_ALU, 1'b1, 5'd3, 1'b0, 5'd0, 1'b0, 5'd0);
    tick();
    enq_valid = 1'b0;
    tick();
    #2;
    chk("pre_rst_busy", busy, 32'h0000_0008);
    exu_ready = 4'b0000;
    for (int i = 0; i < 4; i++) begin
      enq_valid = 1'b1;
      enq_uop = mk(32'h41 + i, EXU_BRU, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0);
      tick();
    end
    enq_valid = 1'b0;
    #2;
    chk("pre_rst_full", enq_ready, 0);
    rst = 1'b1;
    exu_ready = 4'b1111;
    tick();
    #2;
    chk("mid_rst_enq_ready", enq_ready, 1);
    chk("mid_rst_iss_valid", iss_valid, 0);
    chk("mid_rst_iss_fire", iss_fire, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_count", dut.count, 0);
    rst = 1'b0;
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
